seqdet_serializer: RTL and testbench
====================================

Name: seqdet_serializer

Overview:
- Parallel-to-serial stage directly upstream of the sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock on serial output x, which connects to the detector's x input.
- One-entry holding register gives a gapless bit stream across back-to-back words.
- Exposes framing flags (x_valid, x_last) for benches and monitors.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- x  output  1  serial data bit to the detector; registered.
- x_valid  output  1  x carries a real data (or parity) bit this cycle.
- x_last  output  1  high with the final bit of each word.
- busy  output  1  shifter active or holding register occupied.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; shift register, bit counter and holding register cleared; hold_full=0.
  - Outputs: x=0, x_valid=0, x_last=0, busy=0, load_ready=1.
  - Reset asserted mid-word abandons that word and any held word, with no partial flush; the first bit after rst returns high comes only from a new accept.
- Handshake:
  - Accept occurs on a clock edge with load_valid=1 and load_ready=1.
  - load_ready = ~hold_full (combinational from a register).
  - load_data is sampled only on accept.
- States:
  - IDLE: x_valid=0, x=0.
  - SHIFT: one bit per cycle.
  - PAR: only when the optional feature is compiled in.
- Routing an accepted word:
  - Goes straight into the shifter if state is IDLE, or if state is SHIFT/PAR on the word's final bit and hold is empty.
  - Otherwise it goes to the holding register and hold_full=1.
- Latency: accept at edge N from IDLE → first bit on x with x_valid=1 after edge N, i.e. in cycle N+1.
- SHIFT:
  - Bit counter counts 0..WIDTH-1; x/x_valid are updated at each edge.
  - x_last=1 on bit WIDTH-1 (or on the parity bit if enabled).
- End of word:
  - At the edge ending the final bit, the shifter loads the held word if hold_full=1 (hold_full→0 at that same edge), giving the next bit in the next cycle with no gap.
  - Else it loads a directly accepted word; else it returns to IDLE and x_valid=0.
- Simultaneous final-bit edge with hold_full=1 and load_valid=1: no accept (load_ready=0 that cycle); the held word moves to the shifter.
- busy = (state != IDLE) | hold_full.
- No downstream backpressure; the detector is always ready.
- Bit order is fixed per word at load time.

Optional Feature:
- Macro: SEQDET_SER_PARITY_EN.
- Defined:
  - After bit WIDTH-1, state PAR emits one extra bit x = even parity (XOR of all WIDTH data bits) with x_valid=1 and x_last=1.
  - Each word occupies WIDTH+1 cycles; the holding-register handoff happens at the end of PAR.
- Undefined: no PAR state; each word occupies exactly WIDTH cycles; x_last is on the final data bit.

Test Plan:
- Reset, then accept 8'b0110_1010 at edge N, MSB_FIRST=1 → x = 0,1,1,0,1,0,1,0 over cycles N+1..N+8; x_valid=1 throughout; x_last=1 only in cycle N+8; x_valid=0 in cycle N+9; load_ready stays 1.
- MSB_FIRST=0, same word → x = 0,1,0,1,0,1,1,0; x_last on the 8th bit.
- Back-to-back: load_valid held high with words 8'h6A, 8'hB5, 8'h0F → 8'h6A enters the shifter, 8'hB5 the hold, then load_ready=0 until the final bit of 8'h6A; 24 consecutive x_valid cycles with no gap; busy drops one cycle after the last bit of 8'h0F.
- Reset mid-word: assert rst=0 on bit 3 of 8'hFF with hold full → x, x_valid, busy go to 0 immediately (asynchronously); after release, no bits are emitted until a new accept.
- Parity (SEQDET_SER_PARITY_EN defined): 8'h6A → 9 bits, the 9th bit 0 with x_last=1; 8'h6B → 9th bit 1.
- Detector integration: serialize 8'b0110_1010 into the downstream detector → the detector flags the 0110 and 1010 matches at the same bit positions as when the stream is applied directly.

Source files
------------

// File: rtl/seqdet_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: WIDTH-bit words in over valid/ready,
// one bit per clock out on x with a one-entry holding register. Optional parity bit: SEQDET_SER_PARITY_EN.
module seqdet_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef SEQDET_SER_PARITY_EN
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SEQDET_SER_PARITY_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
`ifdef SEQDET_SER_PARITY_EN
    logic             par;
`endif

    logic             accept;
    logic             final_bit;
    logic             ld_go;
    logic             to_hold;
    logic [WIDTH-1:0] ld_word;
    logic [WIDTH-1:0] ld_rest;
    logic [WIDTH-1:0] sreg_shift;
    logic             first_bit;
    logic             next_bit;

    assign load_ready = ~hold_full;
    assign busy       = (state != IDLE) | hold_full;
    assign accept     = load_valid & ~hold_full;

`ifdef SEQDET_SER_PARITY_EN
    assign final_bit = (state == PAR);
`else
    assign final_bit = (state == SHIFT) && (cnt == LAST);
`endif

    // A held word always wins over a new one; load_ready is low whenever the hold is full.
    assign ld_word    = hold_full ? hold_reg : load_data;
    assign ld_go      = ((state == IDLE) && accept) || (final_bit && (hold_full || accept));
    assign to_hold    = accept && (state != IDLE) && !final_bit;
    assign first_bit  = MSB_FIRST ? ld_word[WIDTH-1] : ld_word[0];
    assign ld_rest    = MSB_FIRST ? (ld_word << 1) : (ld_word >> 1);
    assign next_bit   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_shift = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    // NOTE: every register here updates with <= so all right-hand sides see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            // NOTE: the holding register is a plain flop, not a RAM, so it is cleared on reset too.
            hold_reg  <= '0;
            hold_full <= 1'b0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            x_last    <= 1'b0;
`ifdef SEQDET_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            if (to_hold) begin
                hold_reg  <= load_data;
                hold_full <= 1'b1;
            end

            if (ld_go) begin
                state     <= SHIFT;
                sreg      <= ld_rest;
                cnt       <= '0;
                x         <= first_bit;
                x_valid   <= 1'b1;
                x_last    <= 1'b0;
                hold_full <= 1'b0;
`ifdef SEQDET_SER_PARITY_EN
                par       <= ^ld_word;
`endif
            end else if (final_bit) begin
                state   <= IDLE;
                x       <= 1'b0;
                x_valid <= 1'b0;
                x_last  <= 1'b0;
            end else if (state == SHIFT) begin
`ifdef SEQDET_SER_PARITY_EN
                if (cnt == LAST) begin
                    state  <= PAR;
                    x      <= par;
                    x_last <= 1'b1;
                end else
`endif
                begin
                    x    <= next_bit;
                    sreg <= sreg_shift;
                    cnt  <= cnt + CW'(1);
`ifdef SEQDET_SER_PARITY_EN
                    x_last <= 1'b0;
`else
                    x_last <= (cnt == PENULT);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seqdet_serializer.sv
// Bench for seqdet_serializer: MSB-first and LSB-first instances share stimulus and are compared
// every cycle against a bit-queue model; directed cases cover the documented sequences.
module tb_seqdet_serializer;

    localparam int W = 8;
`ifdef SEQDET_SER_PARITY_EN
    localparam int BPW = W + 1;
`else
    localparam int BPW = W;
`endif

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic [1:0]   rdy, xs, xv, xl, bsy;

    seqdet_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy[0]), .x(xs[0]), .x_valid(xv[0]), .x_last(xl[0]), .busy(bsy[0])
    );

    seqdet_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy[1]), .x(xs[1]), .x_valid(xv[1]), .x_last(xl[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: cur_q holds the bits still to appear on x (front = current bit), hold_q the waiting words.
    bit           cur_q[2][$];
    logic [W-1:0] hold_q[2][$];
    int           n_vec = 0;
    int           n_bad = 0;

    logic         cap_x[2][16];
    logic         cap_l[2][16];
    logic         msb_seq[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         lsb_seq[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] words[3]   = '{8'h6A, 8'hB5, 8'h0F};
    logic         acc;
    int           wi, run, maxrun;
    logic [7:0]   stream, direct;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void expand(input int k, input logic [W-1:0] w);
        for (int i = 0; i < W; i++)
            cur_q[k].push_back((k == 0) ? w[W-1-i] : w[i]);
`ifdef SEQDET_SER_PARITY_EN
        cur_q[k].push_back(^w);
`endif
    endfunction

    function automatic void model_step(input logic v, input logic [W-1:0] d);
        for (int k = 0; k < 2; k++) begin
            bit a;
            a = v && (hold_q[k].size() == 0);
            if (cur_q[k].size() > 0) void'(cur_q[k].pop_front());
            if (cur_q[k].size() == 0) begin
                if (hold_q[k].size() > 0) expand(k, hold_q[k].pop_front());
                else if (a) expand(k, d);
            end else if (a) begin
                hold_q[k].push_back(d);
            end
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            cur_q[k].delete();
            hold_q[k].delete();
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic ex;
            ex = (cur_q[k].size() > 0) ? cur_q[k][0] : 1'b0;
            check($sformatf("x[%0d]", k), xs[k], ex);
            check($sformatf("x_valid[%0d]", k), xv[k], cur_q[k].size() > 0);
            check($sformatf("x_last[%0d]", k), xl[k], cur_q[k].size() == 1);
            check($sformatf("busy[%0d]", k), bsy[k], (cur_q[k].size() > 0) || (hold_q[k].size() > 0));
            check($sformatf("load_ready[%0d]", k), rdy[k], hold_q[k].size() == 0);
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        load_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    function automatic logic [7:0] detect(input logic [7:0] s);
        logic [3:0] sh;
        logic [7:0] m;
        sh = '0;
        m  = '0;
        for (int i = 0; i < 8; i++) begin
            sh = {sh[2:0], s[i]};
            if (i >= 3 && (sh == 4'b0110 || sh == 4'b1010)) m[i] = 1'b1;
        end
        return m;
    endfunction

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        #1;
        do_reset();

        // Single word from idle, both bit orders.
        cycle(1'b1, 8'h6A);
        for (int i = 0; i < BPW; i++) begin
            for (int k = 0; k < 2; k++) begin
                cap_x[k][i] = xs[k];
                cap_l[k][i] = xl[k];
            end
            cycle(1'b0, '0);
        end
        check("idle_after_word", xv[0], 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_seq[%0d]", i), cap_x[0][i], msb_seq[i]);
            check($sformatf("lsb_seq[%0d]", i), cap_x[1][i], lsb_seq[i]);
            check($sformatf("last_pos[%0d]", i), cap_l[0][i], i == BPW - 1);
        end
`ifdef SEQDET_SER_PARITY_EN
        check("parity_6A", cap_x[0][8], 1'b0);
        check("parity_6A_last", cap_l[0][8], 1'b1);
`endif

        // Detector integration: match positions on the serialized stream vs the direct stream.
        for (int i = 0; i < 8; i++) begin
            stream[i] = cap_x[0][i];
            direct[i] = msb_seq[i];
        end
        check("detect_positions", detect(stream), detect(direct));

`ifdef SEQDET_SER_PARITY_EN
        cycle(1'b1, 8'h6B);
        repeat (8) cycle(1'b0, '0);
        check("parity_6B", xs[0], 1'b1);
        check("parity_6B_last", xl[0], 1'b1);
        repeat (2) cycle(1'b0, '0);
`endif

        // Back-to-back words with load_valid held high.
        wi = 0;
        run = 0;
        maxrun = 0;
        for (int c = 0; c < 60; c++) begin
            acc = (hold_q[0].size() == 0);
            if (wi < 3) begin
                cycle(1'b1, words[wi]);
                if (acc) wi++;
            end else begin
                cycle(1'b0, '0);
            end
            if (xv[0]) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        check("b2b_words_taken", wi, 3);
        check("b2b_gapless_run", maxrun, 3 * BPW);

        // Reset in the middle of a word with the hold full.
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'hFF);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        check("hold_full_before_rst", rdy[0], 1'b0);
        #2 rst = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_x[%0d]", k), xs[k], 1'b0);
            check($sformatf("rst_x_valid[%0d]", k), xv[k], 1'b0);
            check($sformatf("rst_busy[%0d]", k), bsy[k], 1'b0);
            check($sformatf("rst_ready[%0d]", k), rdy[k], 1'b1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) cycle(1'b0, '0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++)
            cycle($urandom_range(0, 99) < 60, W'($urandom));
        repeat (2 * BPW + 2) cycle(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
